// File: rtl/uart_pkg.sv
// Shared types and constants for the result UART transmitter.
// Frame layout is 8N1: one start bit, eight data bits, one stop bit.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  localparam int BITS_PER_BYTE = 8;
  localparam int FRAME_BITS    = 10;

  function automatic int word_cycles(input int cpb, input int dw);
    return (dw / BITS_PER_BYTE) * FRAME_BITS * cpb;
  endfunction

endpackage

// File: rtl/word_fifo.sv
// Circular word buffer between the result handshake and the serializer.
// Full/empty come from a registered occupancy count, never from pop.
module word_fifo #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic                        pop,
  input  logic [DATA_W-1:0]           wr_data,
  output logic [DATA_W-1:0]           rd_data,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(FIFO_DEPTH):0] count
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = count == (AW+1)'(FIFO_DEPTH);
  assign empty   = count == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/result_uart_tx.sv
// Buffers CPU result words and sends each as LSB-first 8N1 bytes on txd.
// The word being sent lives in a shift register, so the FIFO holds the rest.
import uart_pkg::*;

module result_uart_tx #(
  parameter int CLK_PER_BIT = 4,
  parameter int FIFO_DEPTH  = 4,
  parameter int DATA_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              txd,
  output logic              busy,
  output logic              word_done
);

  localparam int BW     = $clog2(CLK_PER_BIT);
  localparam int NBYTES = DATA_W / BITS_PER_BYTE;
  localparam int YW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int IW     = $clog2(BITS_PER_BYTE);

  localparam logic [BW-1:0] BAUD_MAX  = BW'(CLK_PER_BIT - 1);
  localparam logic [YW-1:0] LAST_BYTE = YW'(NBYTES - 1);
  localparam logic [IW-1:0] LAST_BIT  = IW'(BITS_PER_BYTE - 1);

  tx_state_t                 state;
  logic [BW-1:0]             baud;
  logic [IW-1:0]             bit_idx;
  logic [YW-1:0]             byte_idx;
  logic [DATA_W-1:0]         shreg;
  logic [DATA_W-1:0]         head;
  logic [BITS_PER_BYTE-1:0]  cur;
  logic                      full;
  logic                      empty;
  logic                      pop;
  logic                      tick;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  assign in_ready = !full;
  assign pop      = (state == IDLE) && !empty;
  assign tick     = baud == BAUD_MAX;
  assign cur      = shreg[BITS_PER_BYTE-1:0];

  word_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (in_valid),
    .pop     (pop),
    .wr_data (in_data),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .count   (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      baud      <= '0;
      bit_idx   <= '0;
      byte_idx  <= '0;
      shreg     <= '0;
      txd       <= 1'b1;
      busy      <= 1'b0;
      word_done <= 1'b0;
    end else begin
      word_done <= 1'b0;
      busy      <= (state != IDLE) || (fifo_count != '0);
      baud      <= tick ? '0 : baud + 1'b1;
      unique case (state)
        IDLE: begin
          baud <= '0;
          if (pop) begin
            shreg    <= head;
            byte_idx <= '0;
            txd      <= 1'b0;
            state    <= START;
          end
        end
        START: begin
          if (tick) begin
            bit_idx <= '0;
            txd     <= cur[0];
            state   <= DATA;
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_idx == LAST_BIT) begin
              txd   <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              txd     <= cur[bit_idx + 1'b1];
            end
          end
        end
        STOP: begin
          if (tick) begin
            // Next byte follows the stop bit with no idle gap.
            if (byte_idx != LAST_BYTE) begin
              shreg    <= shreg >> BITS_PER_BYTE;
              byte_idx <= byte_idx + 1'b1;
              txd      <= 1'b0;
              state    <= START;
            end else begin
              word_done <= 1'b1;
              state     <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_result_uart_tx.sv
// Scoreboard bench for result_uart_tx with a cycle-counting UART receiver.
module tb_result_uart_tx;

  localparam int CPB = 4;
  localparam int WORD_CYC = 4 * 10 * CPB;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        txd;
  logic        busy;
  logic        word_done;

  result_uart_tx #(
    .CLK_PER_BIT (CPB),
    .FIFO_DEPTH  (4),
    .DATA_W      (32)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .txd       (txd),
    .busy      (busy),
    .word_done (word_done)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int stalls   = 0;
  int frame_err = 0;

  logic [31:0] exp_q[$];
  logic [31:0] rx_q[$];
  int          rxs_q[$];
  int          wd_q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Receiver: phase counted from the first low cycle, sampled mid-bit.
  int          ph;
  int          k;
  int          nb = 0;
  int          ws_cur;
  logic        rx_act = 1'b0;
  logic [7:0]  rb;
  logic [31:0] rw;

  initial forever begin
    @(negedge clk);
    if (rst) begin
      rx_act = 1'b0;
      nb     = 0;
    end else begin
      if (word_done === 1'b1) wd_q.push_back(cyc);
      if (!rx_act) begin
        if (txd === 1'b0) begin
          rx_act = 1'b1;
          ph     = 0;
          if (nb == 0) ws_cur = cyc;
        end
      end else begin
        ph++;
      end
      if (rx_act && (ph % CPB) == CPB / 2) begin
        k = ph / CPB;
        if (k == 0) begin
          if (txd !== 1'b0) frame_err++;
        end else if (k <= 8) begin
          rb[k-1] = txd;
        end else begin
          if (txd !== 1'b1) frame_err++;
          rw[nb*8 +: 8] = rb;
          nb++;
          rx_act = 1'b0;
          if (nb == 4) begin
            rx_q.push_back(rw);
            rxs_q.push_back(ws_cur);
            nb = 0;
          end
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog cyc=%0d want finish", cyc);
    $fatal(1);
  end

  task automatic send(input logic [31:0] d, output int acc);
    int t = 0;
    in_data  = d;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && t < 1000) begin
      @(negedge clk);
      t++;
      stalls++;
    end
    if (t >= 1000) begin
      n_checks++;
      $display("FAIL send_timeout ready=%b want 1", in_ready);
    end
    acc = cyc;
    exp_q.push_back(d);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_rx(input int n, input int limit);
    int t = 0;
    while (rx_q.size() < n && t < limit) begin
      @(negedge clk);
      t++;
    end
    if (rx_q.size() < n) begin
      n_checks++;
      $display("FAIL rx_timeout got %0d words want %0d", rx_q.size(), n);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic clear_sb();
    exp_q.delete();
    rx_q.delete();
    rxs_q.delete();
    wd_q.delete();
    frame_err = 0;
    stalls    = 0;
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      n_checks++;
      if (txd !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b1 ||
          word_done !== 1'b0)
        $display("FAIL reset_idle c%0d txd=%b busy=%b rdy=%b wd=%b want 1 0 1 0",
                 i, txd, busy, in_ready, word_done);
      else
        n_pass++;
    end
  endtask

  task automatic test_single();
    int          acc;
    logic [31:0] got;
    logic [31:0] exp;
    clear_sb();
    send(32'h1234_5678, acc);
    repeat (20) @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) $display("FAIL single_busy got %b want 1", busy);
    else n_pass++;
    wait_rx(1, 400);
    if (rx_q.size() > 0 && exp_q.size() > 0) begin
      got = rx_q.pop_front();
      exp = exp_q.pop_front();
      for (int b = 0; b < 4; b++) begin
        n_checks++;
        if (got[b*8 +: 8] !== exp[b*8 +: 8])
          $display("FAIL single_byte%0d got %h want %h", b, got[b*8 +: 8], exp[b*8 +: 8]);
        else
          n_pass++;
      end
      n_checks++;
      if (rxs_q[0] !== acc + 2)
        $display("FAIL single_start got cyc %0d want %0d", rxs_q[0], acc + 2);
      else
        n_pass++;
      n_checks++;
      if (wd_q.size() != 1 || wd_q[0] !== rxs_q[0] + WORD_CYC)
        $display("FAIL single_word_done n=%0d got %0d want %0d",
                 wd_q.size(), (wd_q.size() > 0) ? wd_q[0] : -1, rxs_q[0] + WORD_CYC);
      else
        n_pass++;
    end
    n_checks++;
    if (frame_err != 0) $display("FAIL single_frame got %0d errs want 0", frame_err);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] w [6];
    int          acc [6];
    logic [31:0] got;
    logic [31:0] exp;
    clear_sb();
    for (int i = 0; i < 6; i++) w[i] = 32'hC0DE_0000 + 32'(i * 32'h1111);
    for (int i = 0; i < 6; i++) begin
      send(w[i], acc[i]);
      if (i < 5) in_valid = 1'b1;
      if (i == 4) begin
        n_checks++;
        if (in_ready !== 1'b0 || acc[4] !== acc[0] + 4)
          $display("FAIL b2b_full rdy=%b acc4=%0d want 0 %0d", in_ready, acc[4], acc[0] + 4);
        else
          n_pass++;
      end
    end
    n_checks++;
    if (wd_q.size() == 0 || acc[5] !== wd_q[0] + 1)
      $display("FAIL b2b_reready got acc %0d want %0d", acc[5],
               (wd_q.size() > 0) ? wd_q[0] + 1 : -1);
    else
      n_pass++;
    wait_rx(6, 1200);
    for (int i = 0; i < 6 && rx_q.size() > 0; i++) begin
      got = rx_q.pop_front();
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) $display("FAIL b2b_word%0d got %h want %h", i, got, exp);
      else n_pass++;
    end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (rxs_q.size() < 6 || wd_q.size() < 6 || rxs_q[i+1] !== wd_q[i] + 1 ||
          wd_q[i] !== rxs_q[i] + WORD_CYC)
        $display("FAIL b2b_gap%0d start=%0d done=%0d want gap 1",
                 i, (rxs_q.size() > i + 1) ? rxs_q[i+1] : -1,
                 (wd_q.size() > i) ? wd_q[i] : -1);
      else
        n_pass++;
    end
  endtask

  task automatic test_full_random();
    int          acc;
    int          gap;
    logic [31:0] got;
    logic [31:0] exp;
    clear_sb();
    for (int i = 0; i < 100; i++) begin
      send($urandom, acc);
      gap = ($urandom_range(0, 19) == 0) ? 170 : $urandom_range(0, 3);
      repeat (gap) @(negedge clk);
    end
    wait_rx(100, 20000);
    for (int i = 0; i < 100 && rx_q.size() > 0; i++) begin
      got = rx_q.pop_front();
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) $display("FAIL rand_word%0d got %h want %h", i, got, exp);
      else n_pass++;
    end
    n_checks++;
    if (rx_q.size() != 0 || exp_q.size() != 0 || stalls == 0 || frame_err != 0)
      $display("FAIL rand_tail rx=%0d exp=%0d stalls=%0d ferr=%0d want 0 0 >0 0",
               rx_q.size(), exp_q.size(), stalls, frame_err);
    else
      n_pass++;
  endtask

  task automatic test_mid_reset();
    int          acc;
    int          acc2;
    logic        line_ok;
    logic [31:0] got;
    clear_sb();
    send(32'h1122_3344, acc);
    send(32'hDEAD_BEEF, acc2);
    repeat (acc + 102 - cyc) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (txd !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b1 || word_done !== 1'b0)
      $display("FAIL rst_mid txd=%b busy=%b rdy=%b wd=%b want 1 0 1 0",
               txd, busy, in_ready, word_done);
    else
      n_pass++;
    @(negedge clk);
    rst = 1'b0;
    clear_sb();
    line_ok = 1'b1;
    for (int i = 0; i < 250; i++) begin
      @(negedge clk);
      if (txd !== 1'b1 || busy !== 1'b0) line_ok = 1'b0;
    end
    n_checks++;
    if (!line_ok || rx_q.size() != 0 || wd_q.size() != 0)
      $display("FAIL rst_flush line_ok=%b rx=%0d wd=%0d want 1 0 0",
               line_ok, rx_q.size(), wd_q.size());
    else
      n_pass++;
    send(32'hA5A5_A5A5, acc);
    wait_rx(1, 400);
    if (rx_q.size() > 0) begin
      got = rx_q.pop_front();
      n_checks++;
      if (got !== exp_q[0] || frame_err != 0)
        $display("FAIL rst_resume got %h ferr=%0d want %h 0", got, frame_err, exp_q[0]);
      else
        n_pass++;
    end
  endtask

  task automatic test_extremes();
    int          acc;
    logic [31:0] got;
    logic [31:0] exp;
    clear_sb();
    send(32'h0000_0000, acc);
    send(32'hFFFF_FFFF, acc);
    wait_rx(2, 800);
    for (int i = 0; i < 2 && rx_q.size() > 0; i++) begin
      got = rx_q.pop_front();
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) $display("FAIL extreme%0d got %h want %h", i, got, exp);
      else n_pass++;
    end
    n_checks++;
    if (frame_err != 0) $display("FAIL extreme_frame got %0d errs want 0", frame_err);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full_random();
    test_mid_reset();
    test_extremes();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
